// File: rtl/reg_write_arbiter_pkg.sv
// Shared CPU definitions used by the register-file write arbiter.
package reg_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // Register 0 is hard-wired to zero; writes to it are discarded.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // One queued mul/div writeback.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // A write or issue only counts when it is enabled and targets a real register.
  function automatic logic is_live(input logic en, input logic [REG_ADDR_W-1:0] rd);
    return en && (rd != ZERO_REG);
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Pin bundle between the pipeline/mul-div unit and the write arbiter.
// The arbiter exposes these as discrete ports so its pin names match the
// register-file netlist; the bundle is what the surrounding harness wires up.
interface reg_write_arbiter_if;
  import reg_write_arbiter_pkg::*;

  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_data;
  logic                  md_valid;
  logic [REG_ADDR_W-1:0] md_rd;
  logic [DATA_W-1:0]     md_data;
  logic                  md_ready;
  logic                  iss_valid;
  logic [REG_ADDR_W-1:0] iss_rd;
  logic [REG_ADDR_W-1:0] q_rs;
  logic [REG_ADDR_W-1:0] q_rt;
  logic                  stall;
  logic                  wb_hold;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] Write_register;
  logic [DATA_W-1:0]     Write_data;
  logic                  err;

  // Pipeline / mul-div side: drives requests, observes arbitration results.
  modport master (
    output wb_we, wb_rd, wb_data, md_valid, md_rd, md_data, iss_valid, iss_rd, q_rs, q_rt,
    input  md_ready, stall, wb_hold, RegWrite, Write_register, Write_data, err
  );

  // Arbiter side.
  modport slave (
    input  wb_we, wb_rd, wb_data, md_valid, md_rd, md_data, iss_valid, iss_rd, q_rs, q_rt,
    output md_ready, stall, wb_hold, RegWrite, Write_register, Write_data, err
  );

endinterface

// File: rtl/reg_write_arbiter_md_wb_fifo.sv
// Small FIFO holding mul/div results until the register-file write port is free.
module md_wb_fifo
  import reg_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t push_entry,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               do_push, do_pop;

  // Status comes from registered occupancy only, so full/empty never depend on this cycle's requests.
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Next pointer/occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; blocking here would race other flops.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; occupancy alone decides which entries are valid.
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write arbiter: pipeline writeback has priority, mul/div results
// queue in a FIFO, a busy scoreboard tracks outstanding mul/div destinations,
// and a head-age counter asks the pipeline to yield when the queue starves.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  md_ready,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] q_rs,
  input  logic [REG_ADDR_W-1:0] q_rt,
  output logic                  stall,
  output logic                  wb_hold,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] Write_register,
  output logic [DATA_W-1:0]     Write_data,
  output logic                  err
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic        wb_live, iss_live;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_entry_t   fifo_head, push_entry;

  logic [31:0]      busy_q, busy_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             err_q, err_d;

  assign push_entry = '{rd: md_rd, data: md_data};

  md_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .push_entry (push_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  // Handshake and write-port arbitration: a live pipeline write always wins, else drain the FIFO head.
  always_comb begin
    wb_live        = is_live(wb_we, wb_rd);
    iss_live       = is_live(iss_valid, iss_rd);
    md_ready       = ~reset & ~fifo_full;
    // Destination-0 results are accepted on the handshake but never stored.
    fifo_push      = md_valid & md_ready & (md_rd != ZERO_REG);
    fifo_pop       = ~reset & ~wb_live & ~fifo_empty;
    RegWrite       = 1'b0;
    Write_register = fifo_head.rd;
    Write_data     = fifo_head.data;
    if (!reset) begin
      if (wb_live) begin
        RegWrite       = 1'b1;
        Write_register = wb_rd;
        Write_data     = wb_data;
      end else if (!fifo_empty) begin
        RegWrite       = 1'b1;
      end
    end
  end

  // Scoreboard, head-age and protocol-violation tracking.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) busy_d[fifo_head.rd] = 1'b0;
    // Applied after the clear so an issue wins over a same-cycle retirement.
    if (iss_live) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;

    age_d = age_q;
    if (fifo_empty || fifo_pop) age_d = '0;
    else if (age_q != AGE_MAX)  age_d = age_q + AGE_W'(1);

    err_d = err_q
          | (wb_hold & wb_live)
          | (iss_live & busy_q[iss_rd])
          | (wb_live & busy_q[wb_rd])
          | (fifo_push & ~busy_q[md_rd]);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      age_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      age_q  <= age_d;
      err_q  <= err_d;
    end
  end

  assign stall   = busy_q[q_rs] | busy_q[q_rt];
  assign wb_hold = (age_q == AGE_MAX);
  assign err     = err_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a driver issues directed and random
// stimulus, a queue-based reference model predicts each cycle's outputs, and a
// monitor compares them at the falling edge.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_write_arbiter_if bus ();

  reg_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_we          (bus.wb_we),
    .wb_rd          (bus.wb_rd),
    .wb_data        (bus.wb_data),
    .md_valid       (bus.md_valid),
    .md_rd          (bus.md_rd),
    .md_data        (bus.md_data),
    .md_ready       (bus.md_ready),
    .iss_valid      (bus.iss_valid),
    .iss_rd         (bus.iss_rd),
    .q_rs           (bus.q_rs),
    .q_rt           (bus.q_rt),
    .stall          (bus.stall),
    .wb_hold        (bus.wb_hold),
    .RegWrite       (bus.RegWrite),
    .Write_register (bus.Write_register),
    .Write_data     (bus.Write_data),
    .err            (bus.err)
  );

  typedef struct {
    int          cyc;
    bit          rw;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    bit          rdy;
    bit          stall;
    bit          hold;
    bit          err;
  } exp_t;

  // Reference model: pending mul/div results, outstanding destinations, head age, sticky error.
  wb_entry_t m_fifo[$];
  bit        m_busy[32];
  int        m_age;
  bit        m_err;
  int        cyc;

  exp_t       stat_q[$];
  exp_t       wr_q[$];
  logic [4:0] issued_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, c, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_fifo.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_age = 0;
    m_err = 1'b0;
  endfunction

  // Drive one cycle, queue the predicted outputs, then advance the model at the clock edge.
  task automatic step(input bit rst, input bit we, input logic [4:0] wrd, input logic [31:0] wd,
                      input bit mdv, input logic [4:0] mrd, input logic [31:0] md,
                      input bit iss, input logic [4:0] ird, input logic [4:0] qs, input logic [4:0] qt);
    exp_t      e;
    bit        live, rdy, push, pop;
    wb_entry_t h;
    reset         = rst;
    bus.wb_we     = we;
    bus.wb_rd     = wrd;
    bus.wb_data   = wd;
    bus.md_valid  = mdv;
    bus.md_rd     = mrd;
    bus.md_data   = md;
    bus.iss_valid = iss;
    bus.iss_rd    = ird;
    bus.q_rs      = qs;
    bus.q_rt      = qt;

    live    = we && (wrd != 5'd0);
    rdy     = !rst && (m_fifo.size() < DEPTH);
    e.cyc   = cyc;
    e.rw    = !rst && (live || m_fifo.size() > 0);
    e.wreg  = 5'd0;
    e.wdata = 32'd0;
    if (live) begin
      e.wreg  = wrd;
      e.wdata = wd;
    end else if (m_fifo.size() > 0) begin
      e.wreg  = m_fifo[0].rd;
      e.wdata = m_fifo[0].data;
    end
    e.rdy   = rdy;
    e.stall = m_busy[qs] || m_busy[qt];
    e.hold  = (m_age == LIMIT);
    e.err   = m_err;
    stat_q.push_back(e);
    if (e.rw) wr_q.push_back(e);

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      pop  = !live && (m_fifo.size() > 0);
      push = mdv && rdy && (mrd != 5'd0);
      if (e.hold && live)                     m_err = 1'b1;
      if (iss && ird != 5'd0 && m_busy[ird])  m_err = 1'b1;
      if (live && m_busy[wrd])                m_err = 1'b1;
      if (push && !m_busy[mrd])               m_err = 1'b1;
      if (m_fifo.size() == 0 || pop) m_age = 0;
      else if (m_age < LIMIT)        m_age = m_age + 1;
      if (pop) begin
        h = m_fifo.pop_front();
        m_busy[h.rd] = 1'b0;
      end
      if (iss && ird != 5'd0) m_busy[ird] = 1'b1;
      if (push) m_fifo.push_back('{rd: mrd, data: md});
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] qs, input logic [4:0] qt);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, qs, qt);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [4:0] pick_free();
    logic [4:0] r;
    for (int t = 0; t < 8; t++) begin
      r = 5'($urandom_range(1, 31));
      if (!m_busy[r]) return r;
    end
    return 5'd0;
  endfunction

  // Monitor: compare every predicted cycle at the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t w;
    if (stat_q.size() > 0) begin
      e = stat_q.pop_front();
      check("md_ready", e.cyc, 32'(bus.md_ready), 32'(e.rdy));
      check("stall",    e.cyc, 32'(bus.stall),    32'(e.stall));
      check("wb_hold",  e.cyc, 32'(bus.wb_hold),  32'(e.hold));
      check("err",      e.cyc, 32'(bus.err),      32'(e.err));
      check("RegWrite", e.cyc, 32'(bus.RegWrite), 32'(e.rw));
      if (e.rw) begin
        w = wr_q.pop_front();
        if (bus.RegWrite === 1'b1) begin
          check("Write_register", w.cyc, 32'(bus.Write_register), 32'(w.wreg));
          check("Write_data",     w.cyc, bus.Write_data,          w.wdata);
        end
      end
    end
  end

  initial begin
    bit         we, mdv, iss, rdy;
    logic [4:0] wrd, mrd, ird;
    cyc = 0;
    model_reset();
    reset = 1'b1;
    bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.md_valid = 0; bus.md_rd = 0; bus.md_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0; bus.q_rs = 0; bus.q_rt = 0;
    @(posedge clk);
    #1;

    // Values held while reset stays asserted.
    reset_cycles(2);

    // Pipeline write passes straight through in the same cycle.
    step(0, 1, 5'd5, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0, 0);

    // Destination-0 traffic on every source is dropped.
    step(0, 1, 5'd0, 32'hDEAD_BEEF, 1, 5'd0, 32'h1111, 1, 5'd0, 5'd0, 5'd0);
    idle(1, 5'd0, 5'd0);

    // Issue, hazard, enqueue, retire one cycle later.
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0);
    idle(1, 5'd8, 5'd0);
    step(0, 0, 0, 0, 1, 5'd8, 32'h1234, 0, 0, 5'd8, 5'd0);
    idle(3, 5'd8, 5'd0);

    // Two results queued behind four cycles of pipeline writes, then starvation hold and in-order drain.
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd11, 0, 0);
    step(0, 1, 5'd3, 32'h3000_0000, 1, 5'd10, 32'hA0A0, 0, 0, 5'd10, 5'd11);
    step(0, 1, 5'd3, 32'h3000_0001, 1, 5'd11, 32'hB1B1, 0, 0, 5'd10, 5'd11);
    step(0, 1, 5'd3, 32'h3000_0002, 1, 5'd12, 32'hC2C2, 0, 0, 5'd10, 5'd11);
    step(0, 1, 5'd3, 32'h3000_0003, 0, 0, 0, 0, 0, 5'd10, 5'd11);
    idle(4, 5'd10, 5'd11);

    // Double issue raises a sticky error that only reset clears.
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd8, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd8, 0, 0);
    idle(10, 5'd8, 5'd0);
    reset_cycles(2);
    idle(1, 5'd8, 5'd0);

    // Reset with two entries queued discards them.
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd12, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd13, 0, 0);
    step(0, 1, 5'd4, 32'h4444, 1, 5'd12, 32'hCCCC, 0, 0, 5'd12, 5'd13);
    step(0, 1, 5'd4, 32'h4445, 1, 5'd13, 32'hDDDD, 0, 0, 5'd12, 5'd13);
    reset_cycles(1);
    idle(3, 5'd12, 5'd13);

    // Randomized protocol-legal traffic.
    issued_q.delete();
    for (int i = 0; i < 400; i++) begin
      iss = ($urandom_range(0, 9) < 3);
      ird = iss ? pick_free() : 5'd0;
      mdv = 1'b0;
      mrd = 5'd0;
      if (issued_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        mdv = 1'b1;
        mrd = issued_q[0];
      end else if ($urandom_range(0, 4) == 0) begin
        mdv = 1'b1;
      end
      rdy = (m_fifo.size() < DEPTH);
      we  = ($urandom_range(0, 9) < 4) && (m_age != LIMIT);
      wrd = ($urandom_range(0, 9) == 0) ? 5'd0 : pick_free();
      step(0, we, wrd, $urandom(), mdv, mrd, $urandom(), iss, ird,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (mdv && rdy && mrd != 5'd0) void'(issued_q.pop_front());
      if (iss && ird != 5'd0) issued_q.push_back(ird);
    end
    idle(6, 5'd0, 5'd0);

    @(negedge clk);
    #1;
    check("pending_status", cyc, 32'(stat_q.size()), 32'd0);
    check("pending_writes", cyc, 32'(wr_q.size()),   32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
